// File: rtl/exe_pipe_stage_if.sv
// Handshake and bus bundle between the ID/EXE register, the execute stage and MEM.
// Optional forwarding signals exist only when EXE_FWD_EN is defined.
interface exe_pipe_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
);
  // ID/EXE side
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [3:0]        exe_cmd;
  logic              s_bit;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic [DATA_W-1:0] val2;
  logic [23:0]       imm24;
  logic [3:0]        sr_in;
  logic [REG_AW-1:0] dest_in;
`ifdef EXE_FWD_EN
  logic [1:0]        fwd_sel_rn;
  logic [1:0]        fwd_sel_rm;
  logic [DATA_W-1:0] wb_val;
`endif

  // Branch target and MEM side
  logic [DATA_W-1:0] br_addr;
  logic              out_valid;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] st_val;
  logic [REG_AW-1:0] dest;
  logic [3:0]        status_out;
  logic              status_we;

  // Execute stage view
  modport slave (
    input  in_valid, flush, exe_cmd, s_bit, wb_en_in, mem_r_en_in, mem_w_en_in,
    input  pc_in, val_rn, val_rm, val2, imm24, sr_in, dest_in,
`ifdef EXE_FWD_EN
    input  fwd_sel_rn, fwd_sel_rm, wb_val,
`endif
    output in_ready, br_addr, out_valid, wb_en, mem_r_en, mem_w_en,
    output alu_result, st_val, dest, status_out, status_we
  );

  // Upstream driver / downstream observer view
  modport master (
    output in_valid, flush, exe_cmd, s_bit, wb_en_in, mem_r_en_in, mem_w_en_in,
    output pc_in, val_rn, val_rm, val2, imm24, sr_in, dest_in,
`ifdef EXE_FWD_EN
    output fwd_sel_rn, fwd_sel_rm, wb_val,
`endif
    input  in_ready, br_addr, out_valid, wb_en, mem_r_en, mem_w_en,
    input  alu_result, st_val, dest, status_out, status_we
  );
endinterface

// File: rtl/exe_pipe_stage.sv
// ARM execute stage: ALU, NZCV generation, branch-address adder, iterative
// multiplier and the EXE/MEM register. Define EXE_FWD_EN to add operand
// forwarding from the MEM-stage result and the write-back value.
module exe_pipe_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned MUL_STEP = 2
) (
  input  logic            clk,
  input  logic            rst,
  exe_pipe_stage_if.slave pipe
);

  localparam int unsigned STEPS = DATA_W / MUL_STEP;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned SUM_W = DATA_W + 1;
  localparam int unsigned OFF_W = 26;
  localparam int unsigned EXT_W = (DATA_W > OFF_W) ? DATA_W : OFF_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  state_e              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                wb_en_q;
  logic                mem_r_en_q;
  logic                mem_w_en_q;
  logic [DATA_W-1:0]   alu_result_q;
  logic [DATA_W-1:0]   st_val_q;
  logic [REG_AW-1:0]   dest_q;
  logic [3:0]          status_q;
  logic                status_we_q;

  // Multiplier working state and the instruction fields held while it runs
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [DATA_W-1:0]   m_rm_q;
  logic [REG_AW-1:0]   m_dest_q;
  logic                m_wb_q;
  logic                m_mr_q;
  logic                m_mw_q;
  logic                m_s_q;
  logic [1:0]          m_cv_q;

  logic [DATA_W-1:0]   rn_op;
  logic [DATA_W-1:0]   rm_op;
  logic [DATA_W-1:0]   b_op;
  logic                cin;
  logic                is_arith;
  logic [SUM_W-1:0]    sum_w;
  logic [DATA_W-1:0]   alu_res_d;
  logic                flag_c;
  logic                flag_v;
  logic [3:0]          nzcv_d;
  logic [DATA_W-1:0]   mul_acc_d;
  logic                accept;

  logic signed [OFF_W-1:0] br_off;
  logic signed [EXT_W-1:0] br_off_ext;

  assign accept = pipe.in_valid && in_ready_q && !pipe.flush;

`ifdef EXE_FWD_EN
  // Operand forwarding: 01 = MEM-stage result, 10 = write-back value
  always_comb begin
    rn_op = pipe.val_rn;
    rm_op = pipe.val_rm;
    case (pipe.fwd_sel_rn)
      2'b01:   rn_op = alu_result_q;
      2'b10:   rn_op = pipe.wb_val;
      default: rn_op = pipe.val_rn;
    endcase
    case (pipe.fwd_sel_rm)
      2'b01:   rm_op = alu_result_q;
      2'b10:   rm_op = pipe.wb_val;
      default: rm_op = pipe.val_rm;
    endcase
  end
`else
  assign rn_op = pipe.val_rn;
  assign rm_op = pipe.val_rm;
`endif

  // Single-cycle ALU: subtraction is rn + ~val2 + carry-in so C means no borrow
  always_comb begin
    is_arith  = 1'b0;
    b_op      = pipe.val2;
    cin       = 1'b0;
    alu_res_d = '0;
    case (pipe.exe_cmd)
      CMD_MOV: alu_res_d = pipe.val2;
      CMD_MVN: alu_res_d = ~pipe.val2;
      CMD_ADD: is_arith = 1'b1;
      CMD_ADC: begin
        is_arith = 1'b1;
        cin      = pipe.sr_in[1];
      end
      CMD_SUB: begin
        is_arith = 1'b1;
        b_op     = ~pipe.val2;
        cin      = 1'b1;
      end
      CMD_SBC: begin
        is_arith = 1'b1;
        b_op     = ~pipe.val2;
        cin      = pipe.sr_in[1];
      end
      CMD_AND: alu_res_d = rn_op & pipe.val2;
      CMD_ORR: alu_res_d = rn_op | pipe.val2;
      CMD_EOR: alu_res_d = rn_op ^ pipe.val2;
      default: alu_res_d = '0;
    endcase
    sum_w = {1'b0, rn_op} + {1'b0, b_op} + SUM_W'(cin);
    if (is_arith) begin
      alu_res_d = sum_w[DATA_W-1:0];
    end
    flag_c = is_arith ? sum_w[DATA_W] : pipe.sr_in[1];
    flag_v = is_arith ? ((rn_op[DATA_W-1] == b_op[DATA_W-1]) &&
                         (sum_w[DATA_W-1] != rn_op[DATA_W-1]))
                      : pipe.sr_in[0];
    nzcv_d = {alu_res_d[DATA_W-1], (alu_res_d == '0), flag_c, flag_v};
  end

  // One multiplier step: add the shifted multiplicand for each set low multiplier bit
  always_comb begin
    mul_acc_d = acc_q;
    for (int unsigned j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) begin
        mul_acc_d = mul_acc_d + (mcand_q << j);
      end
    end
  end

  // Branch target: word offset sign-extended to the datapath, wraps modulo 2^DATA_W
  assign br_off       = {pipe.imm24, 2'b00};
  assign br_off_ext   = EXT_W'(br_off);
  assign pipe.br_addr = pipe.pc_in + br_off_ext[DATA_W-1:0];

  // Control FSM, multiplier iteration and EXE/MEM register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      alu_result_q <= '0;
      st_val_q     <= '0;
      dest_q       <= '0;
      status_q     <= '0;
      status_we_q  <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      m_rm_q       <= '0;
      m_dest_q     <= '0;
      m_wb_q       <= 1'b0;
      m_mr_q       <= 1'b0;
      m_mw_q       <= 1'b0;
      m_s_q        <= 1'b0;
      m_cv_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      mem_r_en_q  <= 1'b0;
      mem_w_en_q  <= 1'b0;
      status_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (pipe.exe_cmd == CMD_MUL) begin
              state_q    <= ST_BUSY;
              in_ready_q <= 1'b0;
              cnt_q      <= '0;
              acc_q      <= '0;
              mcand_q    <= rn_op;
              mplier_q   <= rm_op;
              m_rm_q     <= rm_op;
              m_dest_q   <= pipe.dest_in;
              m_wb_q     <= pipe.wb_en_in;
              m_mr_q     <= pipe.mem_r_en_in;
              m_mw_q     <= pipe.mem_w_en_in;
              m_s_q      <= pipe.s_bit;
              m_cv_q     <= pipe.sr_in[1:0];
            end else begin
              out_valid_q  <= 1'b1;
              wb_en_q      <= pipe.wb_en_in;
              mem_r_en_q   <= pipe.mem_r_en_in;
              mem_w_en_q   <= pipe.mem_w_en_in;
              alu_result_q <= alu_res_d;
              st_val_q     <= rm_op;
              dest_q       <= pipe.dest_in;
              status_q     <= nzcv_d;
              status_we_q  <= pipe.s_bit;
            end
          end
        end
        ST_BUSY: begin
          if (pipe.flush) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
          end else begin
            acc_q    <= mul_acc_d;
            mcand_q  <= mcand_q << MUL_STEP;
            mplier_q <= mplier_q >> MUL_STEP;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
          if (!pipe.flush) begin
            out_valid_q  <= 1'b1;
            wb_en_q      <= m_wb_q;
            mem_r_en_q   <= m_mr_q;
            mem_w_en_q   <= m_mw_q;
            alu_result_q <= acc_q;
            st_val_q     <= m_rm_q;
            dest_q       <= m_dest_q;
            status_q     <= {acc_q[DATA_W-1], (acc_q == '0), m_cv_q};
            status_we_q  <= m_s_q;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign pipe.in_ready   = in_ready_q;
  assign pipe.out_valid  = out_valid_q;
  assign pipe.wb_en      = wb_en_q;
  assign pipe.mem_r_en   = mem_r_en_q;
  assign pipe.mem_w_en   = mem_w_en_q;
  assign pipe.alu_result = alu_result_q;
  assign pipe.st_val     = st_val_q;
  assign pipe.dest       = dest_q;
  assign pipe.status_out = status_q;
  assign pipe.status_we  = status_we_q;

endmodule

// File: tb/tb_exe_pipe_stage.sv
// Scoreboard bench for exe_pipe_stage: expected EXE/MEM contents are queued
// when an instruction is issued and compared when out_valid is seen.
module tb_exe_pipe_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  localparam logic [3:0] C_MOV = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0100;
  localparam logic [3:0] C_MUL = 4'b1010;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] st;
    logic [3:0]  dest;
    logic [3:0]  nzcv;
    logic        swe;
    logic        wb;
    logic        mr;
    logic        mw;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  exe_pipe_stage_if #(.DATA_W(DW), .REG_AW(AW)) ifc ();

  exe_pipe_stage #(.DATA_W(DW), .REG_AW(AW), .MUL_STEP(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (ifc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                                 input logic [31:0] v2, input logic s, input logic [3:0] sr,
                                 input logic [3:0] d, input logic wb, input logic mr, input logic mw);
    exp_t        e;
    logic [31:0] r;
    logic [63:0] u;
    logic        c, v, cf;
    longint      sa, sb, ss;
    c  = sr[1];
    v  = sr[0];
    cf = sr[1];
    r  = '0;
    sa = longint'($signed(rn));
    sb = longint'($signed(v2));
    case (cmd)
      4'b0001: r = v2;
      4'b1001: r = ~v2;
      4'b0010: begin
        u = {32'b0, rn} + {32'b0, v2};
        r = u[31:0]; c = u[32]; ss = sa + sb; v = (ss > SMAX) || (ss < SMIN);
      end
      4'b0011: begin
        u = {32'b0, rn} + {32'b0, v2} + 64'(cf);
        r = u[31:0]; c = u[32]; ss = sa + sb + longint'(cf); v = (ss > SMAX) || (ss < SMIN);
      end
      4'b0100: begin
        r = rn - v2; c = (rn >= v2); ss = sa - sb; v = (ss > SMAX) || (ss < SMIN);
      end
      4'b0101: begin
        r = rn - v2 - 32'(!cf);
        c = ({32'b0, rn} >= ({32'b0, v2} + 64'(!cf)));
        ss = sa - sb - longint'(!cf); v = (ss > SMAX) || (ss < SMIN);
      end
      4'b0110: r = rn & v2;
      4'b0111: r = rn | v2;
      4'b1000: r = rn ^ v2;
      4'b1010: begin
        u = {32'b0, rn} * {32'b0, rm};
        r = u[31:0];
      end
      default: r = '0;
    endcase
    e.res  = r;
    e.st   = rm;
    e.dest = d;
    e.nzcv = {r[31], (r == 32'd0), c, v};
    e.swe  = s;
    e.wb   = wb;
    e.mr   = mr;
    e.mw   = mw;
    return e;
  endfunction

  // Scoreboard: every out_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && ifc.out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_alu_result", 64'(ifc.alu_result), 64'(e.res));
        check("sb_st_val",     64'(ifc.st_val),     64'(e.st));
        check("sb_dest",       64'(ifc.dest),       64'(e.dest));
        check("sb_nzcv",       64'(ifc.status_out), 64'(e.nzcv));
        check("sb_status_we",  64'(ifc.status_we),  64'(e.swe));
        check("sb_ctrl",       64'({ifc.wb_en, ifc.mem_r_en, ifc.mem_w_en}), 64'({e.wb, e.mr, e.mw}));
      end
    end
  end

  task automatic idle_inputs();
    ifc.in_valid = 1'b0; ifc.flush = 1'b0; ifc.exe_cmd = '0; ifc.s_bit = 1'b0;
    ifc.wb_en_in = 1'b0; ifc.mem_r_en_in = 1'b0; ifc.mem_w_en_in = 1'b0;
    ifc.pc_in = '0; ifc.val_rn = '0; ifc.val_rm = '0; ifc.val2 = '0;
    ifc.imm24 = '0; ifc.sr_in = '0; ifc.dest_in = '0;
`ifdef EXE_FWD_EN
    ifc.fwd_sel_rn = 2'b00; ifc.fwd_sel_rm = 2'b00; ifc.wb_val = '0;
`endif
  endtask

  // Drive one instruction for one cycle; called just after a rising edge
  task automatic send(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                      input logic [31:0] v2, input logic s, input logic [3:0] sr, input logic [3:0] d,
                      input logic wb, input logic mr, input logic mw, input logic fl, input logic exp_out);
    ifc.exe_cmd = cmd; ifc.val_rn = rn; ifc.val_rm = rm; ifc.val2 = v2; ifc.s_bit = s;
    ifc.sr_in = sr; ifc.dest_in = d; ifc.wb_en_in = wb; ifc.mem_r_en_in = mr; ifc.mem_w_en_in = mw;
    ifc.flush = fl; ifc.in_valid = 1'b1;
    if (exp_out) begin
      check("in_ready_at_issue", 64'(ifc.in_ready), 64'd1);
      sb_q.push_back(model(cmd, rn, rm, v2, s, sr, d, wb, mr, mw));
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0; ifc.flush = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int lo;
    idle_inputs();
    rst = 1'b1;
    tick(2);
    check("rst_in_ready",   64'(ifc.in_ready),   64'd1);
    check("rst_out_valid",  64'(ifc.out_valid),  64'd0);
    check("rst_alu_result", 64'(ifc.alu_result), 64'd0);
    check("rst_status",     64'({ifc.status_out, ifc.status_we}), 64'd0);
    check("rst_dest_st",    64'({ifc.dest, ifc.st_val, ifc.wb_en}), 64'd0);
    rst = 1'b0;
    tick(1);

    // ADD 5 + 7 with flags
    send(C_ADD, 32'd5, 32'd0, 32'd7, 1'b1, 4'b0000, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("add_result",    64'(ifc.alu_result), 64'd12);
    check("add_nzcv",      64'(ifc.status_out), 64'd0);
    check("add_status_we", 64'(ifc.status_we),  64'd1);
    check("add_valid",     64'(ifc.out_valid),  64'd1);

    // Bubble: control bits drop, data holds
    tick(1);
    check("bubble_valid", 64'({ifc.out_valid, ifc.wb_en, ifc.status_we}), 64'd0);
    check("bubble_hold",  64'(ifc.alu_result), 64'd12);

    // SUB with signed overflow
    send(C_SUB, 32'h8000_0000, 32'd0, 32'd1, 1'b1, 4'b0000, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sub_result", 64'(ifc.alu_result), 64'h7FFF_FFFF);
    check("sub_nzcv",   64'(ifc.status_out), 64'b0011);

    // Branch adder, including negative offset and wrap-around
    ifc.pc_in = 32'h100; ifc.imm24 = 24'hFFFFFE; #1;
    check("br_neg",  64'(ifc.br_addr), 64'hF8);
    ifc.imm24 = 24'h000010; #1;
    check("br_pos",  64'(ifc.br_addr), 64'h140);
    ifc.pc_in = 32'hFFFF_FFFC; ifc.imm24 = 24'h000001; #1;
    check("br_wrap", 64'(ifc.br_addr), 64'h0);
    ifc.pc_in = '0; ifc.imm24 = '0;

    // MUL: in_ready low for DATA_W/MUL_STEP + 1 cycles, then one result
    send(C_MUL, 32'h1234, 32'h10, 32'd0, 1'b0, 4'b0000, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    lo = 0;
    for (int i = 0; i < 40 && ifc.in_ready == 1'b0; i++) begin
      lo++;
      tick(1);
    end
    check("mul_ready_low_cycles", 64'(lo), 64'd17);
    check("mul_valid",  64'(ifc.out_valid),  64'd1);
    check("mul_result", 64'(ifc.alu_result), 64'h12340);
    send(C_ADD, 32'd1, 32'd0, 32'd2, 1'b1, 4'b0000, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("add_after_mul", 64'(ifc.alu_result), 64'd3);

    // Flush on the 5th BUSY cycle
    send(C_MUL, 32'd7, 32'd9, 32'd0, 1'b1, 4'b0000, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);
    check("busy_not_ready", 64'(ifc.in_ready), 64'd0);
    ifc.flush = 1'b1;
    tick(1);
    ifc.flush = 1'b0;
    check("flush_ready", 64'(ifc.in_ready), 64'd1);
    check("flush_quiet", 64'({ifc.out_valid, ifc.status_we}), 64'd0);
    tick(20);
    check("flush_hold",  64'(ifc.alu_result), 64'd3);

    // Flush together with in_valid drops the instruction
    send(C_MOV, 32'd0, 32'd0, 32'hABCD, 1'b1, 4'b0000, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_drop_valid", 64'(ifc.out_valid),  64'd0);
    check("flush_drop_hold",  64'(ifc.alu_result), 64'd3);

    // Asynchronous reset in the middle of a MUL
    send(C_MUL, 32'd3, 32'd3, 32'd0, 1'b1, 4'b0000, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(5);
    #2 rst = 1'b1;
    #1;
    check("arst_outputs", 64'({ifc.alu_result, ifc.status_out, ifc.dest, ifc.out_valid}), 64'd0);
    check("arst_st_val",  64'(ifc.st_val),   64'd0);
    check("arst_ready",   64'(ifc.in_ready), 64'd1);
    #3 rst = 1'b0;
    tick(1);
    check("post_arst_ready", 64'(ifc.in_ready),  64'd1);
    check("post_arst_valid", 64'(ifc.out_valid), 64'd0);

    // Random single-cycle traffic with occasional bubbles
    for (int k = 0; k < 40; k++) begin
      logic [3:0] cmd;
      cmd = 4'($urandom_range(0, 15));
      if (cmd == C_MUL) cmd = C_SUB;
      send(cmd, $urandom(), $urandom(), (k % 8 == 0) ? 32'h8000_0000 : $urandom(),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b0, 1'b1);
      if ($urandom_range(0, 3) == 0) tick(1);
    end
    // A MUL with random operands and flags
    send(C_MUL, 32'hDEAD_BEEF, 32'h0123_4567, 32'd0, 1'b1, 4'b0110, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(20);

`ifdef EXE_FWD_EN
    // Forward write-back value into rn
    ifc.fwd_sel_rn = 2'b10; ifc.wb_val = 32'd9;
    ifc.exe_cmd = C_ADD; ifc.val_rn = 32'd100; ifc.val_rm = 32'd4; ifc.val2 = 32'd1;
    ifc.s_bit = 1'b0; ifc.sr_in = '0; ifc.dest_in = 4'd1; ifc.wb_en_in = 1'b1;
    ifc.in_valid = 1'b1;
    sb_q.push_back(model(C_ADD, 32'd9, 32'd4, 32'd1, 1'b0, 4'b0000, 4'd1, 1'b1, 1'b0, 1'b0));
    tick(1);
    ifc.in_valid = 1'b0;
    check("fwd_wb_result", 64'(ifc.alu_result), 64'd10);
    // Forward MEM-stage result into rm (store data)
    ifc.fwd_sel_rn = 2'b00; ifc.fwd_sel_rm = 2'b01;
    ifc.exe_cmd = C_MOV; ifc.val_rm = 32'd0; ifc.val2 = 32'd5; ifc.dest_in = 4'd2;
    ifc.in_valid = 1'b1;
    sb_q.push_back(model(C_MOV, 32'd100, 32'd10, 32'd5, 1'b0, 4'b0000, 4'd2, 1'b1, 1'b0, 1'b0));
    tick(1);
    ifc.in_valid = 1'b0; ifc.fwd_sel_rm = 2'b00;
    check("fwd_mem_st_val", 64'(ifc.st_val), 64'd10);
    tick(1);
`endif

    tick(3);
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/exe_pipe_stage.md
Name: exe_pipe_stage

Overview:
- Parametrised execute stage for the ARM pipeline: ALU, branch-address adder, NZCV generation and the EXE/MEM pipeline register in one block.
- Adds what the previous execute stage lacked: valid/ready handshake, pipeline flush, configurable datapath width, and an iterative multi-cycle multiplier that stalls ID.
- Sits between the ID/EXE register and the MEM stage.

Parameters:
- DATA_W, 32, datapath width. Must be even and ≥ 8.
- REG_AW, 4, register-file address width (width of dest).
- MUL_STEP, 2, multiplier bits retired per cycle. Must divide DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  ID/EXE holds a valid instruction
- in_ready  out  1  stage accepts an instruction this cycle
- flush  in  1  kill the instruction being accepted or executing
- exe_cmd  in  4  ALU command
- s_bit  in  1  update status flags
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits passed through to MEM
- pc_in  in  DATA_W  PC+4 of the instruction
- val_rn, val_rm  in  DATA_W  register operands
- val2  in  DATA_W  second operand from the shifter
- imm24  in  24  signed branch offset
- sr_in  in  4  current NZCV
- dest_in  in  REG_AW  destination register
- br_addr  out  DATA_W  combinational: pc_in + (sign-extended imm24 << 2), modulo 2^DATA_W
- out_valid  out  1  registered: MEM-side outputs are valid
- wb_en, mem_r_en, mem_w_en  out  1 each  registered control bits
- alu_result  out  DATA_W  registered result
- st_val  out  DATA_W  registered val_rm, used as store data
- dest  out  REG_AW  registered destination
- status_out  out  4  registered NZCV
- status_we  out  1  registered; one-cycle pulse, aligned with out_valid

Behaviour:
- Reset (asynchronous, active-high): every registered output goes to 0, the FSM goes to IDLE, in_ready = 1.
- exe_cmd encoding:
  - 0001 MOV: val2
  - 1001 MVN: ~val2
  - 0010 ADD: rn + val2
  - 0011 ADC: rn + val2 + C
  - 0100 SUB: rn − val2
  - 0101 SBC: rn − val2 − !C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - 1010 MUL: low DATA_W bits of rn × rm
  - Any other code: result 0, treated as a logic operation.
- Flags:
  - N = result MSB; Z = (result == 0).
  - Add/sub: C = carry out (for subtraction, C = no borrow); V = signed overflow.
  - Logic, MOV/MVN and MUL: C and V copied from sr_in.
- Acceptance: an instruction is accepted when in_valid && in_ready && !flush.
- Single-cycle commands: result is registered at the accepting edge, so out_valid = 1 in the following cycle. status_we = s_bit for that instruction.
- Cycle with no acceptance (bubble, or flush with FSM in IDLE): out_valid, wb_en, mem_r_en, mem_w_en and status_we all register 0. Data outputs hold their previous values.
- MUL state machine: IDLE → BUSY → DONE → IDLE.
  - IDLE, MUL accepted: latch operands, control bits and dest; out_valid ← 0; go to BUSY. in_ready is 0 from the next cycle.
  - BUSY: retire MUL_STEP bits per cycle for DATA_W/MUL_STEP cycles, using a counter from 0 to DATA_W/MUL_STEP − 1. out_valid stays 0.
  - DONE: one cycle. Result, flags and status_we (= latched s_bit) are registered. At the next edge out_valid = 1, the FSM returns to IDLE and in_ready = 1.
  - in_ready is low for DATA_W/MUL_STEP + 1 cycles in total.
- flush during BUSY or DONE: abort; FSM → IDLE; out_valid and status_we register 0 at the next edge; nothing is written.
- flush and in_valid in the same cycle: flush wins and the instruction is dropped.
- Reset mid-MUL: immediate abort, all state cleared.
- No back-pressure from MEM: MEM always accepts.

Optional Feature:
- Macro: EXE_FWD_EN.
- When defined, add ports:
  - fwd_sel_rn, fwd_sel_rm (2 bits each): 00 = register value, 01 = MEM-stage alu_result, 10 = wb_val, 11 = register value.
  - wb_val (DATA_W).
- The selected value replaces val_rn / val_rm for the ALU, multiplier and st_val.
- When undefined: these ports are absent and operands come directly from val_rn / val_rm.

Test Plan:
- ADD, val_rn = 5, val2 = 7, s_bit = 1 → next cycle: alu_result = 12, status_out = 0000, status_we = 1, out_valid = 1.
- SUB, val_rn = 0x80000000, val2 = 1, s_bit = 1 → alu_result = 0x7FFFFFFF, NZCV = 0011.
- MUL, val_rn = 0x1234, val_rm = 0x10, defaults → in_ready low for 17 cycles; then alu_result = 0x12340 with a single out_valid pulse; a following ADD is accepted on the next cycle.
- flush asserted on the 5th BUSY cycle of a MUL → out_valid never rises for it, FSM back in IDLE, in_ready = 1 the next cycle.
- rst pulsed asynchronously (between clock edges) mid-MUL → all outputs 0 immediately, in_ready = 1 after release.
- EXE_FWD_EN: fwd_sel_rn = 10, wb_val = 9, ADD val2 = 1 → alu_result = 10; branch check: pc_in = 0x100, imm24 = 0xFFFFFE → br_addr = 0xF8.
